// File: rtl/memory_map_unit.sv
// memory_map_unit
//   Pipelined, run-time programmable logical-to-physical address translator.
//   A table of NUM_REGIONS entries {base, sizeLog2, phyBase, attr} is searched
//   in parallel for every request. Index 0 has the highest priority. The
//   winning entry produces a physical address {isUncachable, isIO, raw} and a
//   memory-map type. A miss, or an instruction fetch from a non-executable
//   region, produces an ILLEGAL response. A saturating counter tracks how many
//   ILLEGAL responses have been consumed.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   reqValid/reqReady                request handshake
//   reqAddr, reqIsFetch, reqTag      request payload
//   rspValid/rspReady                response handshake
//   rspPhyAddr, rspType, rspTag      response payload (held stable while stalled)
//   cfgWe, cfgIndex, cfgBase,
//   cfgSizeLog2, cfgPhyBase, cfgAttr region table write port, attr = {valid,exec,isIO,isUncachable}
//   cfgLock, locked                  one-way table lock, cleared only by reset
//   faultCount                       saturating count of consumed ILLEGAL responses
module memory_map_unit #(
    parameter int ADDR_WIDTH      = 32,
    parameter int PHY_ADDR_WIDTH  = 32,
    parameter int NUM_REGIONS     = 8,
    parameter int TAG_WIDTH       = 4,
    parameter int FAULT_CNT_WIDTH = 16,
    localparam int IDX_W          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    localparam int RAW_W          = PHY_ADDR_WIDTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic [ADDR_WIDTH-1:0]      reqAddr,
    input  logic                       reqIsFetch,
    input  logic [TAG_WIDTH-1:0]       reqTag,
    output logic                       rspValid,
    input  logic                       rspReady,
    output logic [PHY_ADDR_WIDTH-1:0]  rspPhyAddr,
    output logic [1:0]                 rspType,
    output logic [TAG_WIDTH-1:0]       rspTag,
    input  logic                       cfgWe,
    input  logic [IDX_W-1:0]           cfgIndex,
    input  logic [ADDR_WIDTH-1:0]      cfgBase,
    input  logic [4:0]                 cfgSizeLog2,
    input  logic [RAW_W-1:0]           cfgPhyBase,
    input  logic [3:0]                 cfgAttr,
    input  logic                       cfgLock,
    output logic                       locked,
    output logic [FAULT_CNT_WIDTH-1:0] faultCount
);

    typedef enum logic [1:0] {
        MMT_MEMORY  = 2'd0,
        MMT_IO      = 2'd1,
        MMT_ILLEGAL = 2'd2
    } mmt_e;

    // Region table
    logic [ADDR_WIDTH-1:0] tbl_base [NUM_REGIONS];
    logic [4:0]            tbl_size [NUM_REGIONS];
    logic [RAW_W-1:0]      tbl_phy  [NUM_REGIONS];
    logic [3:0]            tbl_attr [NUM_REGIONS];

    // Stage 1: request plus snapshot of the winning entry
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s1_fetch;
    logic                  s1_hit;
    logic [4:0]            s1_size;
    logic [RAW_W-1:0]      s1_phy;
    logic [2:0]            s1_attr;

    // Stage 2: final result
    logic                      s2_valid;
    logic [PHY_ADDR_WIDTH-1:0] s2_phy;
    mmt_e                      s2_type;
    logic [TAG_WIDTH-1:0]      s2_tag;

    logic                      s2_adv;
    logic                      accept;
    logic                      win_hit;
    logic [4:0]                win_size;
    logic [RAW_W-1:0]          win_phy;
    logic [2:0]                win_attr;
    logic [ADDR_WIDTH-1:0]     offset_mask;
    logic [RAW_W-1:0]          raw_addr;
    logic                      fault;
    logic [PHY_ADDR_WIDTH-1:0] phy_next;
    mmt_e                      type_next;

    // S2 drains whenever its slot is empty or consumed; S1 can always hand
    // over when S2 drains, so reqReady stays high at full throughput.
    assign s2_adv   = !s2_valid || rspReady;
    assign reqReady = !s1_valid || s2_adv;
    assign accept   = reqValid && reqReady;

    assign rspValid   = s2_valid;
    assign rspPhyAddr = s2_phy;
    assign rspType    = s2_type;
    assign rspTag     = s2_tag;

    // Table storage: defaults on reset, writes blocked once locked. A write
    // and a lock in the same cycle still performs the write because the lock
    // only takes effect from the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                tbl_base[i] <= '0;
                tbl_size[i] <= '0;
                tbl_phy[i]  <= '0;
                tbl_attr[i] <= '0;
            end
            tbl_base[0] <= ADDR_WIDTH'(32'h4000_2000);
            tbl_size[0] <= 5'd0;
            tbl_phy[0]  <= RAW_W'(32'h0000_2000);
            tbl_attr[0] <= 4'b1011;
            tbl_base[1] <= ADDR_WIDTH'(32'h4000_0000);
            tbl_size[1] <= 5'd4;
            tbl_phy[1]  <= RAW_W'(32'h0000_0000);
            tbl_attr[1] <= 4'b1011;
            tbl_base[2] <= ADDR_WIDTH'(32'hA000_0000);
            tbl_size[2] <= 5'd29;
            tbl_phy[2]  <= RAW_W'(32'h0000_0000);
            tbl_attr[2] <= 4'b1001;
            tbl_base[3] <= ADDR_WIDTH'(32'h0000_0000);
            tbl_size[3] <= 5'd16;
            tbl_phy[3]  <= RAW_W'(32'h0000_0000);
            tbl_attr[3] <= 4'b1100;
            tbl_base[4] <= ADDR_WIDTH'(32'h8000_0000);
            tbl_size[4] <= 5'd29;
            tbl_phy[4]  <= RAW_W'(32'h0001_0000);
            tbl_attr[4] <= 4'b1100;
        end else if (cfgWe && !locked && (int'(cfgIndex) < NUM_REGIONS)) begin
            tbl_base[cfgIndex] <= cfgBase;
            tbl_size[cfgIndex] <= cfgSizeLog2;
            tbl_phy[cfgIndex]  <= cfgPhyBase;
            tbl_attr[cfgIndex] <= cfgAttr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (cfgLock) begin
            locked <= 1'b1;
        end
    end

    // Parallel region match. Scanning from the top index down lets the
    // lowest matching index overwrite the others, giving index 0 priority.
    // Low base bits below sizeLog2 are shifted out, so misaligned bases are
    // tolerated.
    always_comb begin
        win_hit  = 1'b0;
        win_size = '0;
        win_phy  = '0;
        win_attr = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (tbl_attr[i][3] &&
                ((reqAddr >> tbl_size[i]) == (tbl_base[i] >> tbl_size[i]))) begin
                win_hit  = 1'b1;
                win_size = tbl_size[i];
                win_phy  = tbl_phy[i];
                win_attr = tbl_attr[i][2:0];
            end
        end
    end

    // Translation of the S1 snapshot. The entry was captured at accept time,
    // so table writes after acceptance cannot affect an in-flight request.
    always_comb begin
        offset_mask = (ADDR_WIDTH'(1) << s1_size) - ADDR_WIDTH'(1);
        raw_addr    = s1_phy + RAW_W'(s1_addr & offset_mask);
        fault       = !s1_hit || (s1_fetch && !s1_attr[2]);
        phy_next    = '0;
        type_next   = MMT_MEMORY;
        if (fault) begin
            type_next = MMT_ILLEGAL;
        end else begin
            phy_next  = {s1_attr[0], s1_attr[1], raw_addr};
            type_next = s1_attr[1] ? MMT_IO : MMT_MEMORY;
        end
    end

    // Two-stage pipeline. S2 payload only changes when it advances with a
    // valid S1, so a stalled response holds every rsp* output steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_tag   <= '0;
            s1_fetch <= 1'b0;
            s1_hit   <= 1'b0;
            s1_size  <= '0;
            s1_phy   <= '0;
            s1_attr  <= '0;
            s2_valid <= 1'b0;
            s2_phy   <= '0;
            s2_type  <= MMT_MEMORY;
            s2_tag   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_addr  <= reqAddr;
                s1_tag   <= reqTag;
                s1_fetch <= reqIsFetch;
                s1_hit   <= win_hit;
                s1_size  <= win_size;
                s1_phy   <= win_phy;
                s1_attr  <= win_attr;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_phy  <= phy_next;
                    s2_type <= type_next;
                    s2_tag  <= s1_tag;
                end
            end
        end
    end

    // Fault counter counts ILLEGAL responses on their handshake and sticks
    // at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            faultCount <= '0;
        end else if (s2_valid && rspReady && (s2_type == MMT_ILLEGAL) &&
                     (faultCount != {FAULT_CNT_WIDTH{1'b1}})) begin
            faultCount <= faultCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_map_unit.sv
// tb_memory_map_unit
//   Directed bench for memory_map_unit: a table of single requests against the
//   default map, then hand-written sequences for backpressure, config timing
//   and priority, locking and reset in flight.
module tb_memory_map_unit;

    localparam logic [1:0] T_MEM = 2'd0;
    localparam logic [1:0] T_IO  = 2'd1;
    localparam logic [1:0] T_ILL = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqIsFetch;
    logic [3:0]  reqTag;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspPhyAddr;
    logic [1:0]  rspType;
    logic [3:0]  rspTag;
    logic        cfgWe;
    logic [2:0]  cfgIndex;
    logic [31:0] cfgBase;
    logic [4:0]  cfgSizeLog2;
    logic [29:0] cfgPhyBase;
    logic [3:0]  cfgAttr;
    logic        cfgLock;
    logic        locked;
    logic [15:0] faultCount;

    int checks = 0;
    int errors = 0;
    int expFaults = 0;

    memory_map_unit dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqIsFetch(reqIsFetch), .reqTag(reqTag),
        .rspValid(rspValid), .rspReady(rspReady), .rspPhyAddr(rspPhyAddr),
        .rspType(rspType), .rspTag(rspTag),
        .cfgWe(cfgWe), .cfgIndex(cfgIndex), .cfgBase(cfgBase),
        .cfgSizeLog2(cfgSizeLog2), .cfgPhyBase(cfgPhyBase), .cfgAttr(cfgAttr),
        .cfgLock(cfgLock), .locked(locked), .faultCount(faultCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        fetch;
        logic [1:0]  expType;
        logic [31:0] expPhy;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic f, input logic [3:0] t);
        @(negedge clk);
        reqValid   = 1'b1;
        reqAddr    = a;
        reqIsFetch = f;
        reqTag     = t;
        rspReady   = 1'b1;
    endtask

    // Waits after an accepting edge for the response and consumes it.
    // lat counts falling edges past the first one after the accept edge, so
    // a two-cycle latency gives lat == 1.
    task automatic waitResponse(output logic [1:0] ty, output logic [31:0] pa,
                                output logic [3:0] tg, output int lat);
        lat = 0;
        @(negedge clk);
        reqValid = 1'b0;
        cfgWe    = 1'b0;
        while (!rspValid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        ty = rspType;
        pa = rspPhyAddr;
        tg = rspTag;
        @(posedge clk);
        #1;
    endtask

    task automatic transact(input logic [31:0] a, input logic f, input logic [3:0] t,
                            output logic [1:0] ty, output logic [31:0] pa,
                            output logic [3:0] tg, output int lat);
        applyStimulus(a, f, t);
        @(posedge clk);
        waitResponse(ty, pa, tg, lat);
    endtask

    task automatic writeEntry(input logic [2:0] idx, input logic [31:0] b, input logic [4:0] s,
                              input logic [29:0] p, input logic [3:0] at, input logic lk);
        @(negedge clk);
        cfgWe       = 1'b1;
        cfgIndex    = idx;
        cfgBase     = b;
        cfgSizeLog2 = s;
        cfgPhyBase  = p;
        cfgAttr     = at;
        cfgLock     = lk;
        @(posedge clk);
        #1;
        cfgWe   = 1'b0;
        cfgLock = 1'b0;
    endtask

    logic [1:0]  ty;
    logic [31:0] pa;
    logic [3:0]  tg;
    int          lat;

    logic [1:0]  heldType;
    logic [31:0] heldPhy;
    logic [3:0]  heldTag;
    logic        haveHeld;
    int          stallDiffs;
    int          nextTag;
    int          got;
    logic        fire;
    logic [3:0]  gotTag [4];
    logic [31:0] gotPhy [4];
    int          holes;

    initial begin
        vecs[0]  = '{32'h4000_2000, 1'b0, T_IO,  32'hC000_2000};
        vecs[1]  = '{32'h8000_1234, 1'b0, T_MEM, 32'h0001_1234};
        vecs[2]  = '{32'hC000_0000, 1'b0, T_ILL, 32'h0000_0000};
        vecs[3]  = '{32'hA000_0040, 1'b1, T_ILL, 32'h0000_0000};
        vecs[4]  = '{32'hA000_0040, 1'b0, T_MEM, 32'h8000_0040};
        vecs[5]  = '{32'h4000_000C, 1'b0, T_IO,  32'hC000_000C};
        vecs[6]  = '{32'h4000_0010, 1'b0, T_ILL, 32'h0000_0000};
        vecs[7]  = '{32'h0000_FFFC, 1'b1, T_MEM, 32'h0000_FFFC};
        vecs[8]  = '{32'h0001_0000, 1'b0, T_ILL, 32'h0000_0000};
        vecs[9]  = '{32'h9FFF_FFFF, 1'b0, T_MEM, 32'h2000_FFFF};
        vecs[10] = '{32'h4000_2001, 1'b0, T_ILL, 32'h0000_0000};

        rst_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqIsFetch = 1'b0; reqTag = '0;
        rspReady = 1'b1; cfgWe = 1'b0; cfgIndex = '0; cfgBase = '0; cfgSizeLog2 = '0;
        cfgPhyBase = '0; cfgAttr = '0; cfgLock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_rspValid", {31'b0, rspValid}, 32'd0);
        checkOutput("rst_rspPhyAddr", rspPhyAddr, 32'd0);
        checkOutput("rst_rspType", {30'b0, rspType}, {30'b0, T_MEM});
        checkOutput("rst_rspTag", {28'b0, rspTag}, 32'd0);
        checkOutput("rst_locked", {31'b0, locked}, 32'd0);
        checkOutput("rst_faultCount", {16'b0, faultCount}, 32'd0);
        checkOutput("rst_reqReady", {31'b0, reqReady}, 32'd1);

        $display("[TB] default map vectors");
        for (int i = 0; i < 11; i++) begin
            transact(vecs[i].addr, vecs[i].fetch, 4'(i), ty, pa, tg, lat);
            if (vecs[i].expType == T_ILL) expFaults++;
            checkOutput($sformatf("vec%0d_type", i), {30'b0, ty}, {30'b0, vecs[i].expType});
            checkOutput($sformatf("vec%0d_phy", i), pa, vecs[i].expPhy);
            checkOutput($sformatf("vec%0d_tag", i), {28'b0, tg}, i);
            checkOutput($sformatf("vec%0d_latency", i), lat, 32'd1);
            checkOutput($sformatf("vec%0d_faultCount", i), {16'b0, faultCount}, expFaults);
        end

        $display("[TB] backpressure");
        nextTag = 1; haveHeld = 1'b0; stallDiffs = 0;
        heldType = '0; heldPhy = '0; heldTag = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rspReady = 1'b0;
            reqValid = (nextTag <= 4);
            reqAddr  = 32'h8000_0000 + 32'(nextTag * 4);
            reqTag   = 4'(nextTag);
            reqIsFetch = 1'b0;
            #1;
            fire = reqValid && reqReady;
            if (rspValid) begin
                if (!haveHeld) begin
                    heldType = rspType; heldPhy = rspPhyAddr; heldTag = rspTag; haveHeld = 1'b1;
                end else if (rspType !== heldType || rspPhyAddr !== heldPhy || rspTag !== heldTag) begin
                    stallDiffs++;
                end
            end
            @(posedge clk);
            if (fire) nextTag++;
        end
        checkOutput("bp_accepts_before_stall", nextTag - 1, 32'd2);
        checkOutput("bp_reqReady_low", {31'b0, reqReady}, 32'd0);
        checkOutput("bp_held_tag", {28'b0, heldTag}, 32'd1);
        checkOutput("bp_stable_outputs", stallDiffs, 32'd0);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            rspReady = 1'b1;
            reqValid = (nextTag <= 4);
            reqAddr  = 32'h8000_0000 + 32'(nextTag * 4);
            reqTag   = 4'(nextTag);
            #1;
            fire = reqValid && reqReady;
            if (rspValid) begin
                gotTag[got] = rspTag;
                gotPhy[got] = rspPhyAddr;
                got++;
            end
            @(posedge clk);
            if (fire) nextTag++;
        end
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("bp_response_count", got, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_order_tag%0d", i), {28'b0, gotTag[i]}, i + 1);
            checkOutput($sformatf("bp_order_phy%0d", i), gotPhy[i], 32'h0001_0000 + 32'((i + 1) * 4));
        end

        $display("[TB] config and priority");
        writeEntry(3'd5, 32'h8000_1000, 5'd12, 30'h3_0000, 4'b1000, 1'b0);
        transact(32'h8000_1010, 1'b0, 4'd6, ty, pa, tg, lat);
        checkOutput("cfg_idx5_lower_priority", pa, 32'h0001_1010);
        // write idx0 while a request is accepted on the same edge
        @(negedge clk);
        cfgWe = 1'b1; cfgIndex = 3'd0; cfgBase = 32'h8000_1000; cfgSizeLog2 = 5'd12;
        cfgPhyBase = 30'h3_0000; cfgAttr = 4'b1000;
        reqValid = 1'b1; reqAddr = 32'h8000_1010; reqIsFetch = 1'b0; reqTag = 4'd7; rspReady = 1'b1;
        @(posedge clk);
        waitResponse(ty, pa, tg, lat);
        checkOutput("cfg_same_cycle_old_entry", pa, 32'h0001_1010);
        checkOutput("cfg_same_cycle_tag", {28'b0, tg}, 32'd7);
        transact(32'h8000_1010, 1'b0, 4'd8, ty, pa, tg, lat);
        checkOutput("cfg_idx0_new_entry_phy", pa, 32'h0003_0010);
        checkOutput("cfg_idx0_new_entry_type", {30'b0, ty}, {30'b0, T_MEM});

        $display("[TB] lock");
        @(negedge clk);
        cfgLock = 1'b1;
        @(posedge clk);
        #1;
        cfgLock = 1'b0;
        checkOutput("lock_set", {31'b0, locked}, 32'd1);
        writeEntry(3'd4, 32'h8000_0000, 5'd29, 30'h1_0000, 4'b0000, 1'b0);
        transact(32'h8000_0000, 1'b0, 4'd9, ty, pa, tg, lat);
        checkOutput("lock_write_ignored_type", {30'b0, ty}, {30'b0, T_MEM});
        checkOutput("lock_write_ignored_phy", pa, 32'h0001_0000);

        $display("[TB] reset mid-flight");
        applyStimulus(32'hC000_0000, 1'b0, 4'd10);
        @(posedge clk);
        applyStimulus(32'h8000_0000, 1'b0, 4'd11);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("midflight_rsp_pending", {31'b0, rspValid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midflight_rspValid", {31'b0, rspValid}, 32'd0);
        checkOutput("midflight_faultCount", {16'b0, faultCount}, 32'd0);
        checkOutput("midflight_locked", {31'b0, locked}, 32'd0);
        checkOutput("midflight_rspPhyAddr", rspPhyAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        holes = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rspValid) holes++;
        end
        checkOutput("midflight_no_response", holes, 32'd0);
        transact(32'h4000_2000, 1'b0, 4'd12, ty, pa, tg, lat);
        checkOutput("defaults_idx0_restored", pa, 32'hC000_2000);
        transact(32'h8000_1010, 1'b0, 4'd13, ty, pa, tg, lat);
        checkOutput("defaults_idx4_restored", pa, 32'h0001_1010);

        $display("[TB] write and lock in same cycle");
        writeEntry(3'd0, 32'hC000_0000, 5'd4, 30'h0000_0123, 4'b1000, 1'b1);
        checkOutput("wrlock_locked", {31'b0, locked}, 32'd1);
        transact(32'hC000_0004, 1'b0, 4'd14, ty, pa, tg, lat);
        checkOutput("wrlock_write_done_type", {30'b0, ty}, {30'b0, T_MEM});
        checkOutput("wrlock_write_done_phy", pa, 32'h0000_0127);
        checkOutput("final_faultCount", {16'b0, faultCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
